// File: rtl/pwm_pkg.sv
// Shared constants and types for the prescaled PWM generator.
// Holds the state type plus a helper that turns a divider select into a wrap value.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DIV_W     = 3;
  localparam int unsigned PRE_W     = 7;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // Last prescale count before wrap: 2^sel - 1. The 7-bit arithmetic makes sel=7 give 127.
  function automatic logic [PRE_W-1:0] div_mask(input logic [DIV_W-1:0] sel);
    return (PRE_W'(1) << sel) - PRE_W'(1);
  endfunction

endpackage

// File: rtl/pwm_prescaled_gen_if.sv
// Control/status bundle of the prescaled PWM generator.
// The master side drives the run request and settings; the slave side returns the waveform.
interface pwm_prescaled_gen_if #(
  parameter int unsigned CNT_W = pwm_pkg::CNT_W_DEF
);
  import pwm_pkg::*;

  logic             enable;
  logic [DIV_W-1:0] div_sel;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic             pwm_out;
  logic             tick;
  logic             period_end;
  logic             running;

  modport master (
    output enable, div_sel, period, duty,
    input  pwm_out, tick, period_end, running
  );

  modport slave (
    input  enable, div_sel, period, duty,
    output pwm_out, tick, period_end, running
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Power-of-two prescaler: counts 0..2^div_act-1 and flags the last count.
// clear holds the counter at zero; tick is raw and gated by the caller.
module pwm_prescaler
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_act,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             at_top;

  assign at_top = (pre_q == div_mask(div_act));
  assign tick   = at_top;

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (clear || at_top) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_prescaled_gen.sv
// Prescaled PWM generator: IDLE/RUN control, period counter and shadow settings.
// Settings are sampled on start and at every period end, so mid-period writes never tear a period.
module pwm_prescaled_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  pwm_prescaled_gen_if.slave  bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_act_q;
  logic [CNT_W-1:0] per_act_q;
  logic [CNT_W-1:0] duty_act_q;
  logic             pwm_q;

  logic run;
  logic pre_clear;
  logic pre_tick;
  logic tick_int;
  logic period_end_int;

  assign run            = (state_q == StRun);
  // Clear while idle and on the stopping edge so the prescaler is at 0 whenever RUN starts.
  assign pre_clear      = !(run && bus.enable);
  assign tick_int       = run && pre_tick;
  assign period_end_int = tick_int && (cnt_q == per_act_q);

  pwm_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pre_clear),
    .div_act (div_act_q),
    .tick    (pre_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_act_q  <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      pwm_q <= run && (cnt_q < duty_act_q);
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus.enable) begin
            state_q    <= StRun;
            div_act_q  <= bus.div_sel;
            per_act_q  <= bus.period;
            duty_act_q <= bus.duty;
          end
        end
        StRun: begin
          if (!bus.enable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (period_end_int) begin
            cnt_q      <= '0;
            div_act_q  <= bus.div_sel;
            per_act_q  <= bus.period;
            duty_act_q <= bus.duty;
          end else if (tick_int) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.tick       = tick_int;
  assign bus.period_end = period_end_int;
  assign bus.running    = run;

endmodule

// File: doc/pwm_prescaled_gen.md
PWM_PRESCALED_GEN -- requirements
Module: pwm_prescaled_gen

Interface
REQ-001 Parameter: CNT_W, default 16, width of the period/duty counter and registers.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: enable  input  1  run request; level-sensitive.
REQ-005 Port: div_sel  input  3  prescale select from the divider PIO; divisor = 2^div_sel (1..128).
REQ-006 Port: period  input  CNT_W  PWM period minus one, in prescaled ticks.
REQ-007 Port: duty  input  CNT_W  high time, in prescaled ticks.
REQ-008 Port: pwm_out  output  1  registered PWM waveform.
REQ-009 Port: tick  output  1  one-clk strobe at each prescaled tick.
REQ-010 Port: period_end  output  1  one-clk strobe on the last tick of each PWM period.
REQ-011 Port: running  output  1  high while in RUN state.

Function
REQ-012 FSM states SHALL be IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0, both taking effect on the next clk edge.
REQ-013 On IDLE->RUN the block SHALL load div_sel, period, duty into shadow registers (div_act, per_act, duty_act) and clear the prescale counter and period counter cnt to 0.
REQ-014 In RUN the 7-bit prescale counter SHALL count 0..(2^div_act - 1) and wrap; tick SHALL be 1 for exactly the clk in which the counter equals 2^div_act - 1 (div_act=0: tick=1 every clk).
REQ-015 On a tick, cnt SHALL increment by 1, except when cnt==per_act, where cnt SHALL wrap to 0 and period_end SHALL be 1 in that same clk.
REQ-016 On the period_end clk the shadow registers SHALL reload from div_sel, period, duty; input changes at other times SHALL NOT affect the current period.
REQ-017 pwm_out SHALL be registered as (state==RUN) AND (cnt < duty_act), giving one clk latency from cnt.
REQ-018 PWM period SHALL equal (per_act+1)*2^div_act clks; high time SHALL equal min(duty_act, per_act+1)*2^div_act clks.
REQ-019 duty_act=0 SHALL give pwm_out constantly 0; duty_act>per_act SHALL give constantly 1 (no glitch at wrap).
REQ-020 per_act=0 SHALL make every tick a period_end.
REQ-021 Comparison and counting SHALL be unsigned CNT_W-bit; cnt SHALL never exceed per_act.
REQ-022 enable deasserted mid-period SHALL stop immediately: next clk state=IDLE, cnt=0, prescale counter=0, tick=0, period_end=0; pwm_out=0 one clk later at most.
REQ-023 In IDLE tick, period_end, running SHALL be 0.
REQ-024 enable re-asserted in the clk after deassertion SHALL restart cleanly per REQ-013 with fresh shadow values.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=IDLE, prescale counter=0, cnt=0, all shadow registers=0, pwm_out=0, tick=0, period_end=0, running=0.
REQ-026 Release of reset_n SHALL be followed by IDLE regardless of enable; RUN entered on the first clk edge with enable=1.

Structure
REQ-027 A shared package pwm_pkg SHALL hold CNT_W default, DIV_W=3, PRE_W=7 constants and the IDLE/RUN state type.
REQ-028 The prescaler SHALL be a sub-module pwm_prescaler (inputs clk, reset_n, clear, div_act; output tick); period counter, shadows, FSM and output stay in the top.

Verification
REQ-029 div_sel=0, period=9, duty=3, enable=1 -> pwm_out high 3 clks, low 7 clks, repeating; period_end every 10 clks.
REQ-030 div_sel=2, period=4, duty=2 -> tick every 4 clks; pwm_out high 8 / low 12 clks; period 20 clks.
REQ-031 Running with duty=3 of period=9, change duty to 6 mid-period -> current period keeps 3-tick high; next period high 6 ticks, switch aligned to period_end.
REQ-032 duty=0 then duty=12 with period=9 -> pwm_out constantly 0, then constantly 1 with no low pulse at wrap.
REQ-033 Deassert enable at cnt=5 -> next clk running=0, cnt=0, tick=0; pwm_out 0 within 1 clk; reassert -> first period starts from cnt=0.
REQ-034 Assert reset_n=0 asynchronously mid-period (between clk edges) -> all outputs 0 immediately; after release stays IDLE until enable sampled.
